// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression core: one round per clock, 64 rounds, 66-cycle block period.
// Optional macro SHA256_IV_EN adds a constant FIPS IV output port H256_iv.
module sha256_compress (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_v,
    input  logic [255:0] H256_in,
    input  logic [511:0] M256_in,
    output logic [255:0] H256_out,
    output logic         out_v
`ifdef SHA256_IV_EN
    ,
    output logic [255:0] H256_iv
`endif
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    state_t       state;
    logic [5:0]   t;
    logic [31:0]  a, b, c, d, e, f, g, h;
    logic [31:0]  w [16];
    logic [255:0] hold;

    logic [31:0]  t1, t2, w_next;

    // w[0] is always W[t]; w_next is W[t+16], shifted in at the top of the window
    assign t1     = h + big_s1(e) + ch(e, f, g) + K[t] + w[0];
    assign t2     = big_s0(a) + maj(a, b, c);
    assign w_next = small_s1(w[14]) + w[9] + small_s0(w[1]) + w[0];

`ifdef SHA256_IV_EN
    assign H256_iv = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            t        <= '0;
            {a, b, c, d, e, f, g, h} <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
            hold     <= '0;
            H256_out <= '0;
            out_v    <= 1'b0;
        end else begin
            out_v <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_v) begin
                        hold <= H256_in;
                        {a, b, c, d, e, f, g, h} <= H256_in;
                        for (int i = 0; i < 16; i++) w[i] <= M256_in[511 - 32*i -: 32];
                        t     <= '0;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    h <= g;
                    g <= f;
                    f <= e;
                    e <= d + t1;
                    d <= c;
                    c <= b;
                    b <= a;
                    a <= t1 + t2;
                    for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                    w[15] <= w_next;
                    t     <= t + 6'd1;
                    if (t == 6'd63) state <= DONE;
                end
                DONE: begin
                    H256_out <= {hold[255:224] + a, hold[223:192] + b,
                                 hold[191:160] + c, hold[159:128] + d,
                                 hold[127:96]  + e, hold[95:64]   + f,
                                 hold[63:32]   + g, hold[31:0]    + h};
                    out_v    <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_compress.sv
// Directed bench for sha256_compress: FIPS vectors, chaining, ignored strobes, reset, back-to-back.
module tb_sha256_compress;

    logic         clk;
    logic         reset_n;
    logic         in_v;
    logic [255:0] H256_in;
    logic [511:0] M256_in;
    logic [255:0] H256_out;
    logic         out_v;
`ifdef SHA256_IV_EN
    logic [255:0] H256_iv;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [511:0] M_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] M_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] M_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] M_TWO2  = {480'h0, 32'h000001c0};
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    sha256_compress dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_v     (in_v),
        .H256_in  (H256_in),
        .M256_in  (M256_in),
        .H256_out (H256_out),
        .out_v    (out_v)
`ifdef SHA256_IV_EN
        ,
        .H256_iv  (H256_iv)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts a block at E0, optionally re-pulses in_v at edges pa/pb, watches 140 edges.
    task automatic run_block(input logic [255:0] h_in, input logic [511:0] m_in,
                             input logic [255:0] exp, input bit chk_hash,
                             input int pa, input int pb, input string tag,
                             output logic [255:0] res);
        int first;
        int pulses;
        first  = 0;
        pulses = 0;
        res    = '0;
        @(negedge clk);
        H256_in = h_in;
        M256_in = m_in;
        in_v    = 1'b1;
        @(posedge clk);
        #1;
        in_v = 1'b0;
        for (int n = 1; n <= 140; n++) begin
            in_v = (n == pa) || (n == pb);
            @(posedge clk);
            #1;
            if (out_v) begin
                pulses++;
                if (first == 0) begin
                    first = n;
                    res   = H256_out;
                end
            end
        end
        in_v = 1'b0;
        chk({tag, "_latency"}, 256'(first), 256'(65));
        chk({tag, "_pulses"}, 256'(pulses), 256'(1));
        if (chk_hash) begin
            chk({tag, "_hash"}, res, exp);
            chk({tag, "_hold"}, H256_out, exp);
        end
    endtask

    initial begin
        logic [255:0] r;
        logic [255:0] mid;
        int bad;
        int got65;
        int got131;
        int stray;

        reset_n = 1'b1;
        in_v    = 1'b0;
        H256_in = '0;
        M256_in = '0;
        #2 reset_n = 1'b0;
        #1;
        chk("reset_out_v", 256'(out_v), 256'(0));
        chk("reset_hash", H256_out, 256'h0);
`ifdef SHA256_IV_EN
        chk("iv_port", H256_iv, IV);
`endif
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_out_v", 256'(out_v), 256'(0));

        run_block(IV, M_ABC, D_ABC, 1'b1, 0, 0, "abc", r);
        run_block(IV, M_EMPTY, D_EMPTY, 1'b1, 0, 0, "empty", r);

        run_block(IV, M_TWO1, 256'h0, 1'b0, 0, 0, "two_blk1", mid);
        run_block(mid, M_TWO2, D_TWO, 1'b1, 0, 0, "two_blk2", r);

        run_block(IV, M_ABC, D_ABC, 1'b1, 10, 64, "abc_ignored_strobes", r);

        // Back-to-back: second block accepted on the edge right after the pulse
        got65  = 0;
        got131 = 0;
        bad    = 0;
        @(negedge clk);
        H256_in = IV;
        M256_in = M_ABC;
        in_v    = 1'b1;
        @(posedge clk);
        #1;
        in_v = 1'b0;
        for (int n = 1; n <= 140; n++) begin
            if (n == 66) begin
                H256_in = IV;
                M256_in = M_EMPTY;
                in_v    = 1'b1;
            end else begin
                in_v = 1'b0;
            end
            @(posedge clk);
            #1;
            if (out_v) begin
                if (n == 65) begin
                    got65 = 1;
                    chk("b2b_first_hash", H256_out, D_ABC);
                end else if (n == 131) begin
                    got131 = 1;
                    chk("b2b_second_hash", H256_out, D_EMPTY);
                end else begin
                    bad++;
                end
            end
        end
        in_v = 1'b0;
        chk("b2b_pulse_e65", 256'(got65), 256'(1));
        chk("b2b_pulse_e131", 256'(got131), 256'(1));
        chk("b2b_stray_pulses", 256'(bad), 256'(0));

        // Reset in the middle of ROUND abandons the block and clears the output
        @(negedge clk);
        H256_in = IV;
        M256_in = M_ABC;
        in_v    = 1'b1;
        @(posedge clk);
        #1;
        in_v = 1'b0;
        repeat (20) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("midreset_out_v", 256'(out_v), 256'(0));
        chk("midreset_hash", H256_out, 256'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        stray = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (out_v) stray++;
        end
        chk("midreset_no_pulse", 256'(stray), 256'(0));
        chk("midreset_hash_held", H256_out, 256'h0);

        run_block(IV, M_ABC, D_ABC, 1'b1, 0, 0, "abc_after_reset", r);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
